// File: rtl/gb_cpu_sequencer_pkg.sv
// gb_cpu_sequencer_pkg: shared control-word, schedule and flag types plus condition evaluation.
package gb_cpu_sequencer_pkg;
   localparam int MAX_STEPS = 6;
   typedef enum logic [1:0] {COND_NZ, COND_Z, COND_NC, COND_C} condition_code_t;
   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } alu_flags_t;
   typedef enum logic [2:0] {
      ADDR_BUS_ZERO, ADDR_BUS_PC, ADDR_BUS_SP, ADDR_BUS_HL,
      ADDR_BUS_BC, ADDR_BUS_DE, ADDR_BUS_WZ, ADDR_BUS_HIGH
   } addr_bus_source_t;
   typedef enum logic [3:0] {
      ALU_NOP, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR,
      ALU_CP, ALU_INC, ALU_DEC, ALU_ROT, ALU_BIT, ALU_RES, ALU_SET, ALU_DAA
   } alu_opcode_t;
   typedef enum logic [1:0] {IDU_NOP, IDU_INC, IDU_DEC, IDU_PASS} idu_opcode_t;
   typedef enum logic [3:0] {
      REG_NONE, REG_A, REG_F, REG_B, REG_C, REG_D, REG_E, REG_H,
      REG_L, REG_W, REG_Z, REG_SP, REG_PC, REG_IR, REG_IE, REG_IF
   } reg_sel_t;
   typedef struct packed {
      addr_bus_source_t addr_bus_source;
      logic bus_read;
      logic bus_write;
      reg_sel_t rx_dest;
      reg_sel_t tx_src;
      alu_opcode_t alu_opcode;
      reg_sel_t alu_dest;
      idu_opcode_t idu_opcode;
      reg_sel_t idu_dest;
      logic cc_check;
   } control_signals_t;
   typedef struct packed {
      logic [2:0] m_cycles;
      control_signals_t [MAX_STEPS-1:0] instruction_controls;
      condition_code_t condition;
      logic cb_prefix_next;
      logic bit_cmd;
   } schedule_t;
   localparam control_signals_t CTRL_NOP = '{
      addr_bus_source: ADDR_BUS_ZERO, bus_read: 1'b0, bus_write: 1'b0,
      rx_dest: REG_NONE, tx_src: REG_NONE, alu_opcode: ALU_NOP, alu_dest: REG_NONE,
      idu_opcode: IDU_NOP, idu_dest: REG_NONE, cc_check: 1'b0};
   localparam control_signals_t CTRL_FETCH = '{
      addr_bus_source: ADDR_BUS_PC, bus_read: 1'b1, bus_write: 1'b0,
      rx_dest: REG_IR, tx_src: REG_NONE, alu_opcode: ALU_NOP, alu_dest: REG_NONE,
      idu_opcode: IDU_INC, idu_dest: REG_PC, cc_check: 1'b0};
   localparam schedule_t BOOT_SCHEDULE = '{
      m_cycles: 3'd1,
      instruction_controls: {{(MAX_STEPS-1){CTRL_NOP}}, CTRL_FETCH},
      condition: COND_NZ, cb_prefix_next: 1'b0, bit_cmd: 1'b0};
   function automatic logic cond_met(input condition_code_t cc, input alu_flags_t f);
      return cc == COND_NZ ? !f.z : cc == COND_Z ? f.z : cc == COND_NC ? !f.c : f.c;
   endfunction
endpackage

// File: rtl/gb_cpu_sequencer_if.sv
// gb_cpu_sequencer_if: schedule inputs and per-M-cycle control outputs of the sequencer.
interface gb_cpu_sequencer_if;
   import gb_cpu_sequencer_pkg::*;
   logic m_cycle_en;
   schedule_t schedule_i;
   schedule_t irq_schedule_i;
   logic irq_req_i;
   alu_flags_t flags_i;
   control_signals_t ctrl_o;
   logic [2:0] step_o;
   logic last_o;
   logic cb_mode_o;
   logic bit_cmd_o;
   logic irq_ack_o;
   logic cc_fail_o;
   modport master (
      output m_cycle_en, schedule_i, irq_schedule_i, irq_req_i, flags_i,
      input ctrl_o, step_o, last_o, cb_mode_o, bit_cmd_o, irq_ack_o, cc_fail_o
   );
   modport slave (
      input m_cycle_en, schedule_i, irq_schedule_i, irq_req_i, flags_i,
      output ctrl_o, step_o, last_o, cb_mode_o, bit_cmd_o, irq_ack_o, cc_fail_o
   );
endinterface

// File: rtl/gb_cpu_sequencer.sv
// gb_cpu_sequencer: steps through the active instruction schedule one control word per M-cycle.
module gb_cpu_sequencer
   import gb_cpu_sequencer_pkg::*;
(
   input logic clk,
   input logic reset,
   gb_cpu_sequencer_if.slave bus
);
   schedule_t sched_q;
   logic [2:0] step_q;
   logic cb_q;
   logic irq_ack_q;
   logic [2:0] eff;
   logic last;
   logic take_irq;
   always_comb begin
      eff = sched_q.m_cycles == 3'd0 ? 3'd1
          : sched_q.m_cycles > 3'(MAX_STEPS) ? 3'(MAX_STEPS) : sched_q.m_cycles;
      bus.ctrl_o = sched_q.instruction_controls[step_q];
      bus.cc_fail_o = bus.ctrl_o.cc_check & !cond_met(sched_q.condition, bus.flags_i);
      last = (step_q == eff - 3'd1) | bus.cc_fail_o;
      // never split 0xCB from its suffix; the request simply stays pending
      take_irq = bus.irq_req_i & !sched_q.cb_prefix_next;
      bus.last_o = last;
      bus.step_o = step_q;
      bus.cb_mode_o = cb_q;
      bus.bit_cmd_o = sched_q.bit_cmd;
      bus.irq_ack_o = irq_ack_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sched_q <= BOOT_SCHEDULE;
         step_q <= 3'd0;
         cb_q <= 1'b0;
         irq_ack_q <= 1'b0;
      end else begin
         irq_ack_q <= bus.m_cycle_en & last & take_irq;
         if (bus.m_cycle_en) begin
            step_q <= last ? 3'd0 : step_q + 3'd1;
            if (last) begin
               sched_q <= take_irq ? bus.irq_schedule_i : bus.schedule_i;
               cb_q <= take_irq ? 1'b0 : sched_q.cb_prefix_next;
            end
         end
      end
   end
endmodule
